// File: rtl/ram_loader.sv
// Automated programmer for the 16-byte RAM: writes a streamed byte sequence through
// the manual-programming switch port, optionally reading each byte back to verify.
module ram_loader #(
    parameter logic [3:0]  LAST_ADDR = 4'd15,
    parameter int unsigned WE_PULSE  = 1,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       prog_mode,
    output logic       addr_select,
    output logic [3:0] dipswitch_addr,
    output logic [7:0] dipswitch_data,
    output logic       write_enable_n,
    output logic       bus_enable_n,
    input  logic [7:0] bus_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] error_addr
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SETUP     = 3'd2,
        ST_WRITE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_RD_EN     = 3'd5,
        ST_RD_CMP    = 3'd6,
        ST_FINISH    = 3'd7
    } state_t;

    localparam logic [1:0] WE_LAST = 2'(WE_PULSE - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic [1:0] we_cnt_r;
    logic [1:0] we_cnt_nxt_s;
    logic       accept_s;
    logic       start_s;
    logic       mismatch_s;
    logic       last_s;

    logic       in_ready_r;
    logic       prog_mode_r;
    logic       addr_select_r;
    logic [3:0] dip_addr_r;
    logic [7:0] dip_data_r;
    logic       write_enable_n_r;
    logic       bus_enable_n_r;
    logic       busy_r;
    logic       done_r;
    logic       error_r;
    logic [3:0] error_addr_r;

    assign last_s = (cnt_r == LAST_ADDR);

    // Next-state, counter and event decode for the load sequence
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        we_cnt_nxt_s = we_cnt_r;
        accept_s     = 1'b0;
        start_s      = 1'b0;
        mismatch_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_s      = 1'b1;
                    cnt_nxt_s    = 4'd0;
                    next_state_s = ST_WAIT_BYTE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_BYTE: begin
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_WAIT_BYTE;
                end
            end
            ST_SETUP: begin
                we_cnt_nxt_s = 2'd0;
                next_state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (we_cnt_r == WE_LAST) begin
                    next_state_s = ST_HOLD;
                end else begin
                    we_cnt_nxt_s = we_cnt_r + 2'd1;
                    next_state_s = ST_WRITE;
                end
            end
            ST_HOLD: begin
                if (VERIFY) begin
                    next_state_s = ST_RD_EN;
                end else if (last_s) begin
                    next_state_s = ST_FINISH;
                end else begin
                    cnt_nxt_s    = cnt_r + 4'd1;
                    next_state_s = ST_WAIT_BYTE;
                end
            end
            ST_RD_EN: begin
                next_state_s = ST_RD_CMP;
            end
            ST_RD_CMP: begin
                // A mismatch aborts the load; the bad address is kept for the host
                if (bus_in != dip_data_r) begin
                    mismatch_s   = 1'b1;
                    next_state_s = ST_FINISH;
                end else if (last_s) begin
                    next_state_s = ST_FINISH;
                end else begin
                    cnt_nxt_s    = cnt_r + 4'd1;
                    next_state_s = ST_WAIT_BYTE;
                end
            end
            ST_FINISH: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and latched switch address/data
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            we_cnt_r   <= 2'd0;
            dip_addr_r <= 4'd0;
            dip_data_r <= 8'd0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= cnt_nxt_s;
            we_cnt_r <= we_cnt_nxt_s;
            if (accept_s) begin
                dip_addr_r <= cnt_r;
                dip_data_r <= in_data;
            end
        end
    end

    // Error flag and first-mismatch address
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            error_r      <= 1'b0;
            error_addr_r <= 4'd0;
        end else if (start_s) begin
            error_r <= 1'b0;
        end else if (mismatch_s) begin
            error_r      <= 1'b1;
            error_addr_r <= dip_addr_r;
        end
    end

    // Control outputs registered from the state being entered, so they are glitch-free
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            in_ready_r       <= 1'b0;
            prog_mode_r      <= 1'b1;
            addr_select_r    <= 1'b1;
            write_enable_n_r <= 1'b1;
            bus_enable_n_r   <= 1'b1;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            in_ready_r       <= (next_state_s == ST_WAIT_BYTE);
            prog_mode_r      <= (next_state_s == ST_IDLE) || (next_state_s == ST_FINISH);
            addr_select_r    <= (next_state_s == ST_IDLE) || (next_state_s == ST_FINISH);
            write_enable_n_r <= (next_state_s != ST_WRITE);
            bus_enable_n_r   <= !((next_state_s == ST_RD_EN) || (next_state_s == ST_RD_CMP));
            busy_r           <= !((next_state_s == ST_IDLE) || (next_state_s == ST_FINISH));
            done_r           <= (next_state_s == ST_FINISH);
        end
    end

    assign in_ready       = in_ready_r;
    assign prog_mode      = prog_mode_r;
    assign addr_select    = addr_select_r;
    assign dipswitch_addr = dip_addr_r;
    assign dipswitch_data = dip_data_r;
    assign write_enable_n = write_enable_n_r;
    assign bus_enable_n   = bus_enable_n_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign error_addr     = error_addr_r;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (default and VERIFY=0/LAST_ADDR=3/WE_PULSE=2)
// each driving a behavioural RAM; results compared against a per-load reference model.
module tb_ram_loader;

    logic       clk;
    logic       clr_n;
    logic       start          [2];
    logic [7:0] in_data        [2];
    logic       in_valid       [2];
    logic       in_ready       [2];
    logic       prog_mode      [2];
    logic       addr_select    [2];
    logic [3:0] dip_addr       [2];
    logic [7:0] dip_data       [2];
    logic       write_enable_n [2];
    logic       bus_enable_n   [2];
    logic [7:0] bus_in         [2];
    logic       busy           [2];
    logic       done           [2];
    logic       error          [2];
    logic [3:0] error_addr     [2];

    int p_last [2] = '{15, 3};
    int p_we   [2] = '{1, 2};
    int p_ver  [2] = '{1, 0};

    logic [7:0] mem      [2][16];
    int         wcnt     [2][16];
    int         corrupt  [2];
    logic       fill     [2];
    int         we_run   [2];
    int         pulse_err[2];
    int         bus_err  [2];
    int         stab_err [2];
    int         be_low   [2];
    int         acc_cnt  [2];
    logic       prev_we  [2];
    logic       prev_acc [2];
    logic       prev_clr [2];
    logic [3:0] prev_addr[2];
    logic [7:0] prev_data[2];

    logic [7:0] bytes [16];
    int n_checks;
    int n_pass;

    ram_loader u_dut_a (
        .clk(clk), .clr_n(clr_n), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .prog_mode(prog_mode[0]),
        .addr_select(addr_select[0]), .dipswitch_addr(dip_addr[0]),
        .dipswitch_data(dip_data[0]), .write_enable_n(write_enable_n[0]),
        .bus_enable_n(bus_enable_n[0]), .bus_in(bus_in[0]), .busy(busy[0]),
        .done(done[0]), .error(error[0]), .error_addr(error_addr[0])
    );

    ram_loader #(.LAST_ADDR(4'd3), .WE_PULSE(2), .VERIFY(1'b0)) u_dut_b (
        .clk(clk), .clr_n(clr_n), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .prog_mode(prog_mode[1]),
        .addr_select(addr_select[1]), .dipswitch_addr(dip_addr[1]),
        .dipswitch_data(dip_data[1]), .write_enable_n(write_enable_n[1]),
        .bus_enable_n(bus_enable_n[1]), .bus_in(bus_in[1]), .busy(busy[1]),
        .done(done[1]), .error(error[1]), .error_addr(error_addr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read path
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            bus_in[g] = 8'h00;
            if (!bus_enable_n[g]) bus_in[g] = mem[g][dip_addr[g]];
        end
    end

    // RAM write path plus bus/strobe/stability monitors, sampled mid-cycle
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (fill[g]) begin
                for (int a = 0; a < 16; a++) begin
                    mem[g][a]  <= 8'hEE;
                    wcnt[g][a] <= 0;
                end
                pulse_err[g] <= 0;
                bus_err[g]   <= 0;
                stab_err[g]  <= 0;
                be_low[g]    <= 0;
                acc_cnt[g]   <= 0;
                we_run[g]    <= 0;
            end else begin
                if (!write_enable_n[g]) begin
                    mem[g][dip_addr[g]] <= (int'(dip_addr[g]) == corrupt[g]) ? 8'hA5 : dip_data[g];
                    if (prev_we[g]) wcnt[g][dip_addr[g]] <= wcnt[g][dip_addr[g]] + 1;
                    we_run[g] <= we_run[g] + 1;
                end else begin
                    if (we_run[g] != 0 && we_run[g] != p_we[g]) pulse_err[g] <= pulse_err[g] + 1;
                    we_run[g] <= 0;
                end
                if (!bus_enable_n[g]) be_low[g] <= be_low[g] + 1;
                if (!bus_enable_n[g] && !write_enable_n[g]) bus_err[g] <= bus_err[g] + 1;
                if (in_valid[g] && in_ready[g]) acc_cnt[g] <= acc_cnt[g] + 1;
                if ((dip_addr[g] != prev_addr[g] || dip_data[g] != prev_data[g]) &&
                    !prev_acc[g] && prev_clr[g])
                    stab_err[g] <= stab_err[g] + 1;
            end
            prev_we[g]   <= write_enable_n[g];
            prev_acc[g]  <= in_valid[g] && in_ready[g];
            prev_clr[g]  <= clr_n;
            prev_addr[g] <= dip_addr[g];
            prev_data[g] <= dip_data[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [23:0] outs(input int i);
        return {prog_mode[i], addr_select[i], write_enable_n[i], bus_enable_n[i],
                in_ready[i], busy[i], done[i], error[i], error_addr[i],
                dip_addr[i], dip_data[i]};
    endfunction

    task automatic run_load(input int i, input int maxgap, input bit poke,
                            output int done_edge, output int ndone);
        int  idx, edge_n, gap, after;
        bit  acc, poked;
        @(posedge clk); #1;
        fill[i] = 1'b1;
        @(posedge clk); #1;
        fill[i]     = 1'b0;
        start[i]    = 1'b1;
        in_valid[i] = 1'b1;
        in_data[i]  = bytes[0];
        @(posedge clk); #1;
        start[i]  = 1'b0;
        edge_n    = 0;
        idx       = 0;
        gap       = 0;
        after     = 0;
        poked     = 1'b0;
        done_edge = -1;
        ndone     = 0;
        while (edge_n < 400 && after < 4) begin
            @(negedge clk);
            acc = in_valid[i] && in_ready[i];
            if (done[i]) begin
                ndone++;
                if (done_edge < 0) done_edge = edge_n;
            end
            if (ndone > 0) after++;
            @(posedge clk);
            edge_n++;
            #1;
            start[i] = 1'b0;
            if (acc) begin
                idx++;
                in_valid[i] = 1'b0;
                gap = int'($urandom_range(maxgap, 0));
            end
            if (!in_valid[i] && idx < 16) begin
                if (gap == 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = bytes[idx];
                end else begin
                    gap--;
                end
            end
            if (poke && !poked && idx == 7) begin
                start[i] = 1'b1;
                poked    = 1'b1;
            end
        end
        in_valid[i] = 1'b0;
    endtask

    task automatic check_load(input int i, input int maxgap, input int done_edge, input int ndone);
        int         n, per;
        bit         err;
        logic [7:0] exp_b;
        per = 3 + p_we[i] + ((p_ver[i] != 0) ? 2 : 0);
        if (p_ver[i] != 0 && corrupt[i] >= 0 && corrupt[i] <= p_last[i]) begin
            n   = corrupt[i] + 1;
            err = 1'b1;
        end else begin
            n   = p_last[i] + 1;
            err = 1'b0;
        end
        chk("done_count", ndone, 1);
        if (maxgap == 0) chk("done_latency", done_edge, n * per);
        chk("error", error[i], err);
        if (err) chk("error_addr", error_addr[i], corrupt[i]);
        chk("busy_end", busy[i], 1'b0);
        chk("prog_mode_end", prog_mode[i], 1'b1);
        chk("addr_select_end", addr_select[i], 1'b1);
        chk("accepted", acc_cnt[i], n);
        for (int a = 0; a < 16; a++) begin
            if (a < n) exp_b = (a == corrupt[i]) ? 8'hA5 : bytes[a];
            else       exp_b = 8'hEE;
            chk($sformatf("mem[%0d]", a), mem[i][a], exp_b);
            chk($sformatf("writes[%0d]", a), wcnt[i][a], (a < n) ? 1 : 0);
        end
        chk("we_pulse_len", pulse_err[i], 0);
        chk("bus_overlap", bus_err[i], 0);
        chk("addr_data_stable", stab_err[i], 0);
        chk("bus_en_cycles", be_low[i], (p_ver[i] != 0) ? 2 * n : 0);
    endtask

    initial begin
        int de, nd, budget, nd_rst;
        n_checks = 0;
        n_pass   = 0;
        clr_n    = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g]    = 1'b0;
            in_valid[g] = 1'b0;
            in_data[g]  = 8'h00;
            fill[g]     = 1'b0;
            corrupt[g]  = -1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_a", outs(0), 24'hF00000);
        chk("reset_outs_b", outs(1), 24'hF00000);
        @(posedge clk); #1;
        clr_n = 1'b1;

        // ascending bytes, ideal RAM
        for (int a = 0; a < 16; a++) bytes[a] = 8'(a);
        run_load(0, 0, 1'b0, de, nd);
        check_load(0, 0, de, nd);

        // RAM corrupts address 5
        corrupt[0] = 5;
        run_load(0, 0, 1'b0, de, nd);
        check_load(0, 0, de, nd);
        corrupt[0] = -1;

        // random data, gappy source
        for (int a = 0; a < 16; a++) bytes[a] = 8'($urandom);
        run_load(0, 3, 1'b0, de, nd);
        check_load(0, 3, de, nd);

        // random data, stray start during byte 7
        for (int a = 0; a < 16; a++) bytes[a] = 8'($urandom);
        run_load(0, 0, 1'b1, de, nd);
        check_load(0, 0, de, nd);

        // no-verify short instance
        for (int a = 0; a < 16; a++) bytes[a] = 8'($urandom);
        run_load(1, 0, 1'b0, de, nd);
        check_load(1, 0, de, nd);

        // reset asserted mid-WRITE of address 3, after an aborted load left error_addr=5
        corrupt[0] = 5;
        for (int a = 0; a < 16; a++) bytes[a] = 8'(a);
        run_load(0, 0, 1'b0, de, nd);
        corrupt[0] = -1;
        @(posedge clk); #1;
        start[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h5A;
        @(posedge clk); #1;
        start[0] = 1'b0;
        budget   = 0;
        nd_rst   = 0;
        @(negedge clk);
        while (!(write_enable_n[0] == 1'b0 && dip_addr[0] == 4'd3) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("midreset_reached_write", budget < 200, 1'b1);
        clr_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outs_a_1", outs(0), 24'hF00000);
        chk("midreset_outs_b_1", outs(1), 24'hF00000);
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outs_a_2", outs(0), 24'hF00000);
        clr_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[0]) nd_rst++;
            chk("idle_after_reset", in_ready[0], 1'b0);
        end
        chk("no_done_on_reset", nd_rst, 0);
        in_valid[0] = 1'b0;

        // fresh load after reset restarts from address 0
        for (int a = 0; a < 16; a++) bytes[a] = 8'($urandom);
        run_load(0, 0, 1'b0, de, nd);
        check_load(0, 0, de, nd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
